// File: rtl/ar_watchpoint_unit.sv
// Masked address watchpoints with hit counters feeding a level-7 freeze FSM (IDLE/PEND/FROZEN/REARM).
// Defining WP_DATA_MATCH_EN adds a per-channel write-data compare register at channel offset +7.
module ar_watchpoint_unit #(
  parameter int          CHANNELS     = 4,
  parameter int          CNT_W        = 8,
  parameter logic [22:0] QUAL_TOP     = 23'h1FF,
  parameter int          REARM_CYCLES = 2
) (
  input  logic                clk,
  input  logic                _reset,
  input  logic [22:0]         cpu_address_in,
  input  logic                _cpu_as,
  input  logic                cpu_rd,
  input  logic                cpu_hwr,
  input  logic                cpu_lwr,
  input  logic [15:0]         data_in,
  input  logic                reg_sel,
  input  logic [5:0]          reg_address,
  output logic [15:0]         data_out,
  input  logic                freeze,
  input  logic                int7_ack,
  output logic                int7,
  output logic                active,
  output logic [CHANNELS-1:0] hit
);
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_FROZEN, S_REARM} state_t;

  state_t                         state_q, state_d;
  logic [CHANNELS-1:0][22:0]      addr_q, addr_d, mask_q, mask_d;
  logic [CHANNELS-1:0][4:0]       ctrl_q, ctrl_d;
  logic [CHANNELS-1:0][CNT_W-1:0] preset_q, preset_d, count_q, count_d;
`ifdef WP_DATA_MATCH_EN
  logic [CHANNELS-1:0][15:0]      dcmp_q, dcmp_d;
`endif
  logic                gen_q, gen_d;
  logic [22:0]         cap_addr_q, cap_addr_d, last_addr_q, last_addr_d;
  logic [15:0]         cap_data_q, cap_data_d;
  logic                src_frz_q, src_frz_d;
  logic [2:0]          src_idx_q, src_idx_d;
  logic                int7_q, int7_d, active_q, active_d;
  logic [CHANNELS-1:0] hit_q, hit_d;
  logic                qual_prev_q, qual_prev_d, as_q, as_d, sampled_q, sampled_d;
  logic                we_q, we_d, freeze_q, freeze_d;
  logic [3:0]          rearm_q, rearm_d;

  logic                we_raw, we, cyc, as_rise, frz_rise, resume, wr_any;
  logic [2:0]          grp, off;
  logic [CHANNELS-1:0] match, fire, dat_ok;

  assign wr_any   = cpu_hwr | cpu_lwr;
  assign we_raw   = reg_sel & wr_any;
  assign we       = we_raw & ~we_q;
  // A bus cycle is looked at exactly once, on its first clock with a strobe.
  assign cyc      = ~_cpu_as & (cpu_rd | wr_any) & ~sampled_q;
  assign as_rise  = _cpu_as & ~as_q;
  assign frz_rise = freeze & ~freeze_q;
  assign resume   = we && (reg_address == 6'd4) && data_in[0];
  assign grp      = reg_address[5:3];
  assign off      = reg_address[2:0];

  always_comb begin
    dat_ok = '1;
    match  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
`ifdef WP_DATA_MATCH_EN
      dat_ok[c] = (~cpu_hwr | (data_in[15:8] == dcmp_q[c][15:8])) &
                  (~cpu_lwr | (data_in[7:0]  == dcmp_q[c][7:0]));
`endif
      match[c] = ctrl_q[c][0] & gen_q &
                 (((cpu_address_in ^ addr_q[c]) & ~mask_q[c]) == 23'd0) &
                 ((ctrl_q[c][1] & cpu_rd) | (ctrl_q[c][2] & wr_any & dat_ok[c])) &
                 (~ctrl_q[c][3] | qual_prev_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    ctrl_d      = ctrl_q;
    preset_d    = preset_q;
    count_d     = count_q;
`ifdef WP_DATA_MATCH_EN
    dcmp_d      = dcmp_q;
`endif
    gen_d       = gen_q;
    cap_addr_d  = cap_addr_q;
    cap_data_d  = cap_data_q;
    src_frz_d   = src_frz_q;
    src_idx_d   = src_idx_q;
    int7_d      = int7_q;
    active_d    = active_q;
    rearm_d     = rearm_q;
    hit_d       = '0;
    fire        = '0;
    as_d        = _cpu_as;
    freeze_d    = freeze;
    we_d        = we_raw;
    sampled_d   = ~_cpu_as & (sampled_q | cyc);
    last_addr_d = _cpu_as ? last_addr_q : cpu_address_in;
    qual_prev_d = as_rise ? (last_addr_q <= QUAL_TOP) : qual_prev_q;

    case (state_q)
      S_IDLE: begin
        if (cyc) begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (match[c]) begin
              hit_d[c] = 1'b1;
              if (count_q[c] != '0) begin
                count_d[c] = count_q[c] - CNT_W'(1);
              end else begin
                fire[c] = 1'b1;
                if (ctrl_q[c][4]) count_d[c] = preset_q[c];
              end
            end
          end
        end
        if (frz_rise || (fire != '0)) begin
          state_d    = S_PEND;
          int7_d     = 1'b1;
          cap_addr_d = cpu_address_in;
          cap_data_d = data_in;
          src_frz_d  = frz_rise;
          src_idx_d  = '0;
          // Button beats channels; descending scan leaves the lowest firing index.
          if (!frz_rise) begin
            for (int c = CHANNELS - 1; c >= 0; c--) begin
              if (fire[c]) src_idx_d = 3'(c);
            end
          end
        end
      end
      S_PEND: begin
        if (int7_ack) begin
          int7_d   = 1'b0;
          active_d = 1'b1;
          state_d  = S_FROZEN;
        end
      end
      S_FROZEN: begin
        if (resume) begin
          active_d = 1'b0;
          rearm_d  = '0;
          state_d  = S_REARM;
        end
      end
      default: begin
        if (as_rise) begin
          if (rearm_q == 4'(REARM_CYCLES - 1)) state_d = S_IDLE;
          else                                  rearm_d = rearm_q + 4'd1;
        end
      end
    endcase

    // Register writes come last so a CPU write beats a same-clock counter update.
    if (we) begin
      if (reg_address == 6'd4) gen_d = data_in[1];
      for (int c = 0; c < CHANNELS; c++) begin
        if (grp == 3'(c + 1)) begin
          case (off)
            3'd0: addr_d[c][22:15] = data_in[7:0];
            3'd1: addr_d[c][14:0]  = data_in[15:1];
            3'd2: mask_d[c][22:15] = data_in[7:0];
            3'd3: mask_d[c][14:0]  = data_in[15:1];
            3'd4: ctrl_d[c]        = data_in[4:0];
            3'd5: begin
              preset_d[c] = data_in[CNT_W-1:0];
              count_d[c]  = data_in[CNT_W-1:0];
            end
`ifdef WP_DATA_MATCH_EN
            3'd7: dcmp_d[c] = data_in;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (reg_sel && cpu_rd) begin
      if (grp == 3'd0) begin
        case (off)
          3'd0: data_out = {active_q, state_q == S_PEND, src_frz_q, 10'd0, src_idx_q};
          3'd1: data_out = {8'd0, cap_addr_q[22:15]};
          3'd2: data_out = {cap_addr_q[14:0], 1'b0};
          3'd3: data_out = cap_data_q;
          3'd4: data_out = {14'd0, gen_q, 1'b0};
          default: ;
        endcase
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (grp == 3'(c + 1)) begin
          case (off)
            3'd0: data_out = {8'd0, addr_q[c][22:15]};
            3'd1: data_out = {addr_q[c][14:0], 1'b0};
            3'd2: data_out = {8'd0, mask_q[c][22:15]};
            3'd3: data_out = {mask_q[c][14:0], 1'b0};
            3'd4: data_out = 16'(ctrl_q[c]);
            3'd5: data_out = 16'(preset_q[c]);
            3'd6: data_out = 16'(count_q[c]);
`ifdef WP_DATA_MATCH_EN
            3'd7: data_out = dcmp_q[c];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      ctrl_q      <= '0;
      preset_q    <= '0;
      count_q     <= '0;
`ifdef WP_DATA_MATCH_EN
      dcmp_q      <= '0;
`endif
      gen_q       <= 1'b0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      src_frz_q   <= 1'b0;
      src_idx_q   <= '0;
      int7_q      <= 1'b0;
      active_q    <= 1'b0;
      hit_q       <= '0;
      rearm_q     <= '0;
      qual_prev_q <= 1'b0;
      as_q        <= 1'b1;
      sampled_q   <= 1'b0;
      we_q        <= 1'b0;
      freeze_q    <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      ctrl_q      <= ctrl_d;
      preset_q    <= preset_d;
      count_q     <= count_d;
`ifdef WP_DATA_MATCH_EN
      dcmp_q      <= dcmp_d;
`endif
      gen_q       <= gen_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      src_frz_q   <= src_frz_d;
      src_idx_q   <= src_idx_d;
      int7_q      <= int7_d;
      active_q    <= active_d;
      hit_q       <= hit_d;
      rearm_q     <= rearm_d;
      qual_prev_q <= qual_prev_d;
      as_q        <= as_d;
      sampled_q   <= sampled_d;
      we_q        <= we_d;
      freeze_q    <= freeze_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign int7   = int7_q;
  assign active = active_q;
  assign hit    = hit_q;
endmodule

// File: tb/tb_ar_watchpoint_unit.sv
// Scoreboard bench for ar_watchpoint_unit: per-cycle hit and register-read expectations are queued and checked.
module tb_ar_watchpoint_unit;
  localparam int CH = 4;
  localparam logic [22:0] REGA = 23'h7C0000;
  localparam logic [22:0] T0   = 23'h5FF000;
  localparam logic [22:0] T1   = 23'h091A28;
  localparam logic [22:0] T2   = 23'h008000;

  logic          clk = 1'b0;
  logic          rst_n, as_n, cpu_rd, hwr, lwr, reg_sel, freeze, ack;
  logic [22:0]   addr;
  logic [15:0]   din, dout;
  logic [5:0]    ra;
  logic          int7, active;
  logic [CH-1:0] hit;
  logic [15:0]   r;

  int total = 0;
  int bad   = 0;
  logic [CH-1:0] hit_exp_q[$];
  logic [15:0]   rd_exp_q[$];

  ar_watchpoint_unit #(.CHANNELS(CH), .CNT_W(8), .QUAL_TOP(23'h1FF), .REARM_CYCLES(2)) dut (
    .clk(clk), ._reset(rst_n), .cpu_address_in(addr), ._cpu_as(as_n), .cpu_rd(cpu_rd),
    .cpu_hwr(hwr), .cpu_lwr(lwr), .data_in(din), .reg_sel(reg_sel), .reg_address(ra),
    .data_out(dout), .freeze(freeze), .int7_ack(ack), .int7(int7), .active(active), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle starting at a negedge; hit is sampled on each following negedge.
  task automatic cyc(input logic [22:0] a, input logic rd, input logic hw, input logic lw,
                     input logic [15:0] d, input logic rs, input logic [5:0] ra_i, input logic frz,
                     input logic [CH-1:0] exp_hit, input string tag, output logic [15:0] rdat);
    logic [CH-1:0] acc;
    logic [CH-1:0] e;
    int n;
    acc = '0;
    n = 0;
    rdat = '0;
    hit_exp_q.push_back(exp_hit);
    addr = a; cpu_rd = rd; hwr = hw; lwr = lw; din = d; reg_sel = rs; ra = ra_i; as_n = 1'b0;
    if (frz) freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (hit != '0) begin
        acc |= hit;
        n++;
      end
      if (i == 1) begin
        rdat = dout;
        as_n = 1'b1; cpu_rd = 1'b0; hwr = 1'b0; lwr = 1'b0; reg_sel = 1'b0;
      end
    end
    e = hit_exp_q.pop_front();
    chk({tag, "_hit"}, (32'(n) << 8) | 32'(acc), (32'(e != '0) << 8) | 32'(e));
  endtask

  task automatic rreg(input logic [5:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] v;
    rd_exp_q.push_back(exp);
    cyc(REGA, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, a, 1'b0, '0, tag, v);
    chk(tag, 32'(v), 32'(rd_exp_q.pop_front()));
  endtask

  task automatic wreg(input logic [5:0] a, input logic [15:0] d);
    logic [15:0] v;
    cyc(REGA, 1'b0, 1'b1, 1'b1, d, 1'b1, a, 1'b0, '0, $sformatf("w%0d", a), v);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; as_n = 1'b1; cpu_rd = 1'b0; hwr = 1'b0; lwr = 1'b0; reg_sel = 1'b0;
    ra = '0; din = '0; addr = '0; freeze = 1'b0; ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_int7", 32'(int7), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_hit", 32'(hit), 0);
    rreg(6'd0, 16'h0000, "rst_status");

    // Qualifier window on channel 0
    wreg(6'd4, 16'h0002);
    wreg(6'd8, 16'h00BF);
    wreg(6'd9, 16'hE000);
    wreg(6'd12, 16'h000B);
    rreg(6'd9, 16'hE000, "ch0_addr_lo");
    cyc(23'h000080, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0000, "q_low", r);
    cyc(T0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0001, "q_hit", r);
    chk("q_int7", 32'(int7), 1);
    rreg(6'd0, 16'h4000, "q_status");
    rreg(6'd1, 16'h00BF, "cap_hi");
    rreg(6'd2, 16'hE000, "cap_lo");
    do_ack();
    chk("ack_int7", 32'(int7), 0);
    chk("ack_active", 32'(active), 1);
    rreg(6'd0, 16'h8000, "frozen_status");
    wreg(6'd4, 16'h0003);
    chk("resume_active", 32'(active), 0);
    rreg(6'd0, 16'h0000, "rearm_status");
    cyc(23'h000200, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0000, "q_out", r);
    cyc(T0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0000, "q_miss", r);
    chk("q_miss_int7", 32'(int7), 0);
    cyc(23'h000080, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0000, "q_low2", r);
    cyc(T0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0001, "q_hit2", r);
    chk("q_hit2_int7", 32'(int7), 1);

    // Hit counter on channel 1, without then with autoreload
    for (int ar = 0; ar < 2; ar++) begin
      do_reset();
      wreg(6'd4, 16'h0002);
      wreg(6'd16, 16'h0012);
      wreg(6'd17, 16'h3450);
      wreg(6'd20, (ar != 0) ? 16'h0015 : 16'h0005);
      wreg(6'd21, 16'h0003);
      rreg(6'd22, 16'h0003, "cnt_init");
      for (int k = 0; k < 4; k++) begin
        cyc(T1, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 6'd0, 1'b0, 4'b0010, $sformatf("cnt_wr%0d", k), r);
        chk($sformatf("cnt_int7_%0d", k), 32'(int7), (k == 3) ? 1 : 0);
        if (k < 3) rreg(6'd22, 16'(2 - k), $sformatf("cnt_val%0d", k));
      end
      rreg(6'd22, (ar != 0) ? 16'h0003 : 16'h0000, "cnt_final");
      rreg(6'd0, 16'h4001, "cnt_status");
    end

    // Freeze and channel 2 in the same clock
    do_reset();
    wreg(6'd4, 16'h0002);
    wreg(6'd24, 16'h0001);
    wreg(6'd25, 16'h0000);
    wreg(6'd28, 16'h0003);
    cyc(T2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1, 4'b0100, "frz_same", r);
    chk("frz_int7", 32'(int7), 1);
    rreg(6'd0, 16'h6000, "frz_status");
    do_ack();
    chk("frz_ack_int7", 32'(int7), 0);
    chk("frz_ack_active", 32'(active), 1);
    rreg(6'd0, 16'hA000, "frz_frozen_status");

    // Frozen: triggers ignored, counters hold
    freeze = 1'b0;
    @(negedge clk);
    wreg(6'd29, 16'h0002);
    cyc(T2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1, 4'b0000, "frozen_try", r);
    rreg(6'd0, 16'hA000, "frozen_hold_status");
    rreg(6'd30, 16'h0002, "frozen_count");
    freeze = 1'b0;
    wreg(6'd29, 16'h0000);
    wreg(6'd4, 16'h0003);
    chk("rearm_active", 32'(active), 0);
    cyc(T2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0000, "rearm_blk", r);
    chk("rearm_int7", 32'(int7), 0);
    cyc(23'h000100, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0000, "rearm_dummy", r);
    cyc(T2, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0, 4'b0100, "rearm_hit", r);
    chk("rearm_hit_int7", 32'(int7), 1);
    rreg(6'd0, 16'h4002, "rearm_status");

    // Asynchronous reset while pending
    #2 rst_n = 1'b0;
    #1;
    chk("arst_int7", 32'(int7), 0);
    chk("arst_active", 32'(active), 0);
    reg_sel = 1'b1; cpu_rd = 1'b1; ra = 6'd24;
    #1 chk("arst_ch2_addr_hi", 32'(dout), 0);
    ra = 6'd4;
    #1 chk("arst_gctrl", 32'(dout), 0);
    ra = 6'd0;
    #1 chk("arst_status", 32'(dout), 0);
    reg_sel = 1'b0; cpu_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Data compare register at +7
    wreg(6'd4, 16'h0002);
    wreg(6'd8, 16'h0012);
    wreg(6'd9, 16'h3450);
    wreg(6'd12, 16'h0005);
    wreg(6'd15, 16'h12AB);
`ifdef WP_DATA_MATCH_EN
    rreg(6'd15, 16'h12AB, "dm_reg");
    cyc(T1, 1'b0, 1'b1, 1'b1, 16'h12AC, 1'b0, 6'd0, 1'b0, 4'b0000, "dm_word_miss", r);
    chk("dm_miss_int7", 32'(int7), 0);
    cyc(T1, 1'b0, 1'b0, 1'b1, 16'h00AB, 1'b0, 6'd0, 1'b0, 4'b0001, "dm_byte_hit", r);
    chk("dm_hit_int7", 32'(int7), 1);
`else
    rreg(6'd15, 16'h0000, "dm_reg");
    cyc(T1, 1'b0, 1'b1, 1'b1, 16'h12AC, 1'b0, 6'd0, 1'b0, 4'b0001, "dm_off_hit", r);
    chk("dm_off_int7", 32'(int7), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ar_watchpoint_unit.md
Name: ar_watchpoint_unit

Overview:
- Parametrised successor to the cartridge breakpoint logic: CHANNELS independent address watchpoints with mask, access-type filter, instruction-window qualifier and hit counters.
- Triggers drive a level-7 freeze request. A freeze FSM with an explicit re-arm phase lets a resume re-enable breakpoints reliably.
- Sits beside the cartridge controller on the CPU bus. Registers are CPU-visible through reg_sel, and data_out is ORed onto the CPU read bus.

Parameters:
- CHANNELS, 4, number of watchpoints (1..7).
- CNT_W, 8, hit-counter width (1..16).
- QUAL_TOP, 23'h1FF, highest word address of the qualifier window (default $000-$3FF).
- REARM_CYCLES, 2, number of completed bus cycles after resume before triggers are armed (1..15).

Ports:
- clk  in  1  system clock.
- _reset  in  1  asynchronous active-low reset.
- cpu_address_in  in  23  CPU word address [23:1].
- _cpu_as  in  1  CPU address strobe, active low.
- cpu_rd  in  1  CPU read cycle.
- cpu_hwr  in  1  upper-byte write strobe.
- cpu_lwr  in  1  lower-byte write strobe.
- data_in  in  16  CPU write data.
- reg_sel  in  1  register window select (decoded externally).
- reg_address  in  6  register word offset.
- data_out  out  16  register read data; 0 when not (reg_sel & cpu_rd).
- freeze  in  1  freeze button, level.
- int7_ack  in  1  level-7 interrupt acknowledge cycle.
- int7  out  1  level-7 request.
- active  out  1  frozen; monitor owns the machine.
- hit  out  CHANNELS  one-clock pulse per matching channel.

Behaviour:
- Reset values: int7=0, active=0, hit=0. All registers are 0, FSM is IDLE, the previous-cycle qualifier flag is 0.
- Register writes take effect on the first clk where reg_sel & (cpu_hwr|cpu_lwr). Writes are full-word, one per strobe assertion.
- Global registers:
  - 0: STATUS (RO). [15] frozen, [14] pending, [13] source=freeze, [2:0] channel index.
  - 1: CAP_HI (RO), [7:0] = captured A[23:16].
  - 2: CAP_LO (RO), captured A[15:1] in [15:1].
  - 3: CAP_DATA (RO), data_in at trigger.
  - 4: GCTRL. bit0 resume (write-only, self-clearing); bit1 global enable.
  - 5-7: read 0.
- Channel c registers at offset 8+8c:
  - +0 ADDR_HI[7:0].
  - +1 ADDR_LO[15:1].
  - +2 MASK_HI.
  - +3 MASK_LO (1 = don't care).
  - +4 CTRL: bit0 enable, bit1 match read, bit2 match write, bit3 require qualifier, bit4 autoreload.
  - +5 PRESET. A write also loads the live count.
  - +6 COUNT (RO, live count).
  - +7 DATA (see Optional Feature).
  - Unimplemented channels read 0.
- Cycle sampling:
  - A bus cycle is evaluated once, on the first clk with _cpu_as low and (cpu_rd|cpu_hwr|cpu_lwr).
  - On _cpu_as rising edge, qual_prev <= (last cycle address <= QUAL_TOP). This flag is used for the next cycle.
- Channel match requires all of:
  - enable and GCTRL.en.
  - ((addr ^ ADDR) & ~MASK) == 0.
  - (rd & cpu_rd) | (wr & (cpu_hwr|cpu_lwr)).
  - (!qual | qual_prev).
- Matches and counters operate only in IDLE.
- On a channel match, hit[c] pulses for one clk.
- Counter handling on a match:
  - If COUNT != 0, decrement it.
  - If COUNT == 0, the channel fires. With autoreload, COUNT <= PRESET in the same clk.
- FSM IDLE:
  - A freeze rising edge or any channel fire goes to PEND.
  - Capture the address and data, set int7=1, set source/index.
  - Freeze wins over channels; among channels the lowest index wins.
  - All matching channels still update their counters.
- FSM PEND:
  - On int7_ack: int7=0, active=1, go to FROZEN.
  - Further freeze edges and hits are ignored.
- FSM FROZEN:
  - Counters hold and the freeze button is ignored.
  - A resume write goes to REARM and sets active=0.
- FSM REARM:
  - Count REARM_CYCLES _cpu_as rising edges, then go to IDLE.
  - Triggers are blocked during REARM.
  - Resume writes outside FROZEN are ignored.
- Asynchronous reset in any state returns everything to reset values immediately. int7 drops without an ack.

Optional Feature:
- Macro: WP_DATA_MATCH_EN.
- When defined, offset +7 is a per-channel data compare register. Write matches additionally require:
  - data_in[15:8]==DATA[15:8] if cpu_hwr.
  - data_in[7:0]==DATA[7:0] if cpu_lwr.
  - Read matches ignore data.
- When undefined, +7 reads 0, writes are dropped and no data compare is made.

Test Plan:
- Ch0 ADDR=$BFE001>>1, MASK=0, CTRL=rd|qual|en, GCTRL.en=1.
  - Read $BFE001 right after a cycle at $000100 -> hit[0] pulse, int7=1, STATUS=$4000.
  - Same read after a cycle at $000400 -> no hit.
- Ch1 PRESET=3, CTRL=wr|en, four writes to target -> COUNT reads 2,1,0, int7 on the 4th write.
  - With autoreload set, COUNT reads 3 afterwards.
- Freeze edge and ch2 match in the same clk -> STATUS[13]=1. int7_ack -> int7=0, active=1, STATUS[15]=1.
- In FROZEN: freeze edges and matching accesses -> no state change, counters hold.
  - Resume with REARM_CYCLES=2 -> a match during the 1st bus cycle is ignored; a match after the 2nd completed cycle triggers.
- _reset low while PEND -> int7=0, active=0, all registers 0 at once.
- WP_DATA_MATCH_EN, ch0 DATA=$12AB:
  - Byte write $AB with lwr only -> trigger.
  - Word write $12AC -> no trigger.
